// File: rtl/sha256_compress_ctrl.sv
// Iterative SHA-256 compression engine: one round per clock around a shared
// round datapath, start/ready handshake in, one-cycle done pulse out.
module sha256_compress_ctrl #(
    parameter int unsigned NUM_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [511:0] block_in,
    input  logic [255:0] state_in,
    output logic         ready,
    output logic         done,
    output logic [255:0] digest_out
);

    localparam int unsigned RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

    state_t          r_state;
    logic [RW-1:0]   r_rnd;
    logic [31:0]     r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    logic [31:0]     r_hc [8];
    logic [31:0]     r_w  [16];
    logic            r_ready;
    logic            r_done;
    logic [255:0]    r_digest;

    logic [31:0]     w_k;
    logic [31:0]     w_t1;
    logic [31:0]     w_t2;
    logic [31:0]     w_wnew;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] k_const(input logic [5:0] idx);
        case (idx)
            6'd0:  return 32'h428a2f98; 6'd1:  return 32'h71374491;
            6'd2:  return 32'hb5c0fbcf; 6'd3:  return 32'he9b5dba5;
            6'd4:  return 32'h3956c25b; 6'd5:  return 32'h59f111f1;
            6'd6:  return 32'h923f82a4; 6'd7:  return 32'hab1c5ed5;
            6'd8:  return 32'hd807aa98; 6'd9:  return 32'h12835b01;
            6'd10: return 32'h243185be; 6'd11: return 32'h550c7dc3;
            6'd12: return 32'h72be5d74; 6'd13: return 32'h80deb1fe;
            6'd14: return 32'h9bdc06a7; 6'd15: return 32'hc19bf174;
            6'd16: return 32'he49b69c1; 6'd17: return 32'hefbe4786;
            6'd18: return 32'h0fc19dc6; 6'd19: return 32'h240ca1cc;
            6'd20: return 32'h2de92c6f; 6'd21: return 32'h4a7484aa;
            6'd22: return 32'h5cb0a9dc; 6'd23: return 32'h76f988da;
            6'd24: return 32'h983e5152; 6'd25: return 32'ha831c66d;
            6'd26: return 32'hb00327c8; 6'd27: return 32'hbf597fc7;
            6'd28: return 32'hc6e00bf3; 6'd29: return 32'hd5a79147;
            6'd30: return 32'h06ca6351; 6'd31: return 32'h14292967;
            6'd32: return 32'h27b70a85; 6'd33: return 32'h2e1b2138;
            6'd34: return 32'h4d2c6dfc; 6'd35: return 32'h53380d13;
            6'd36: return 32'h650a7354; 6'd37: return 32'h766a0abb;
            6'd38: return 32'h81c2c92e; 6'd39: return 32'h92722c85;
            6'd40: return 32'ha2bfe8a1; 6'd41: return 32'ha81a664b;
            6'd42: return 32'hc24b8b70; 6'd43: return 32'hc76c51a3;
            6'd44: return 32'hd192e819; 6'd45: return 32'hd6990624;
            6'd46: return 32'hf40e3585; 6'd47: return 32'h106aa070;
            6'd48: return 32'h19a4c116; 6'd49: return 32'h1e376c08;
            6'd50: return 32'h2748774c; 6'd51: return 32'h34b0bcb5;
            6'd52: return 32'h391c0cb3; 6'd53: return 32'h4ed8aa4a;
            6'd54: return 32'h5b9cca4f; 6'd55: return 32'h682e6ff3;
            6'd56: return 32'h748f82ee; 6'd57: return 32'h78a5636f;
            6'd58: return 32'h84c87814; 6'd59: return 32'h8cc70208;
            6'd60: return 32'h90befffa; 6'd61: return 32'ha4506ceb;
            6'd62: return 32'hbef9a3f7; default: return 32'hc67178f2;
        endcase
    endfunction

    // Round datapath and message-schedule next word
    assign w_k    = k_const(6'(r_rnd));
    assign w_t1   = r_h + (ror(r_e, 6) ^ ror(r_e, 11) ^ ror(r_e, 25))
                  + ((r_e & r_f) ^ (~r_e & r_g)) + w_k + r_w[0];
    assign w_t2   = (ror(r_a, 2) ^ ror(r_a, 13) ^ ror(r_a, 22))
                  + ((r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c));
    assign w_wnew = (ror(r_w[14], 17) ^ ror(r_w[14], 19) ^ (r_w[14] >> 10))
                  + r_w[9]
                  + (ror(r_w[1], 7) ^ ror(r_w[1], 18) ^ (r_w[1] >> 3))
                  + r_w[0];

    // Control FSM, working registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rnd    <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_digest <= '0;
            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
            for (int i = 0; i < 8; i++)  r_hc[i] <= '0;
            for (int i = 0; i < 16; i++) r_w[i]  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (start && !abort) begin
                        for (int i = 0; i < 16; i++) r_w[i] <= block_in[511 - 32*i -: 32];
                        for (int i = 0; i < 8; i++)  r_hc[i] <= state_in[255 - 32*i -: 32];
                        {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= state_in;
                        r_rnd   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (abort) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_h <= r_g;
                        r_g <= r_f;
                        r_f <= r_e;
                        r_e <= r_d + w_t1;
                        r_d <= r_c;
                        r_c <= r_b;
                        r_b <= r_a;
                        r_a <= w_t1 + w_t2;
                        for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
                        r_w[15] <= w_wnew;
                        r_rnd   <= r_rnd + RW'(1);
                        if (r_rnd == RW'(NUM_ROUNDS - 1)) r_state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                    if (!abort) begin
                        r_digest <= {32'(r_hc[0] + r_a), 32'(r_hc[1] + r_b),
                                     32'(r_hc[2] + r_c), 32'(r_hc[3] + r_d),
                                     32'(r_hc[4] + r_e), 32'(r_hc[5] + r_f),
                                     32'(r_hc[6] + r_g), 32'(r_hc[7] + r_h)};
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign done       = r_done;
    assign digest_out = r_digest;

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// Directed self-checking bench for sha256_compress_ctrl using known SHA-256 vectors.
module tb_sha256_compress_ctrl;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [255:0] IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [511:0] block_in;
    logic [255:0] state_in;
    logic         ready;
    logic         done;
    logic [255:0] digest_out;

    int checks = 0;
    int errors = 0;

    sha256_compress_ctrl #(.NUM_ROUNDS(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .block_in   (block_in),
        .state_in   (state_in),
        .ready      (ready),
        .done       (done),
        .digest_out (digest_out)
    );

    always #5 clk = ~clk;

    // Present a block while ready is high; returns #1 after the accept edge with inputs scrambled.
    task automatic accept_block(input logic [511:0] blk, input logic [255:0] st);
        start    = 1'b1;
        block_in = blk;
        state_in = st;
        @(posedge clk); #1;
        start    = 1'b0;
        block_in = {16{32'hdeadbeef}};
        state_in = {8{32'h12345678}};
    endtask

    // Count edges until done; cycles stays -1 if the budget runs out.
    task automatic wait_done(input int budget, output int cycles, output logic [255:0] dig,
                             output int ready_bad);
        cycles = -1; dig = '0; ready_bad = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                cycles = i; dig = digest_out;
                break;
            end
            if (ready !== 1'b0) ready_bad++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; block_in = '0; state_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (digest_out !== 256'h0) begin errors++; $display("FAIL reset_digest got %h want 0", digest_out); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_abc;
        int cyc, rb; logic [255:0] d;
        accept_block(BLK_ABC, IV);
        wait_done(200, cyc, d, rb);
        checks++; if (cyc !== 65) begin errors++; $display("FAIL abc_latency got %0d want 65", cyc); end
        checks++; if (d !== DIG_ABC) begin errors++; $display("FAIL abc_digest got %h want %h", d, DIG_ABC); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abc_ready_at_done got %b want 1", ready); end
        checks++; if (rb !== 0) begin errors++; $display("FAIL abc_ready_in_round got %0d cycles high want 0", rb); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abc_done_pulse got %b want 0", done); end
    endtask

    task automatic test_empty;
        int cyc, rb; logic [255:0] d;
        accept_block(BLK_EMPTY, IV);
        wait_done(200, cyc, d, rb);
        checks++; if (cyc !== 65) begin errors++; $display("FAIL empty_latency got %0d want 65", cyc); end
        checks++; if (d !== DIG_EMPTY) begin errors++; $display("FAIL empty_digest got %h want %h", d, DIG_EMPTY); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_start;
        int cyc, rb, extra;
        logic [255:0] d;
        accept_block(BLK_ABC, IV);
        cyc = -1; rb = 0; d = '0;
        for (int i = 1; i <= 200; i++) begin
            start = (i == 6 || i == 41);
            block_in = start ? BLK_EMPTY : {16{32'hdeadbeef}};
            state_in = start ? ~IV : {8{32'h12345678}};
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin cyc = i; d = digest_out; break; end
            if (ready !== 1'b0) rb++;
        end
        checks++; if (cyc !== 65) begin errors++; $display("FAIL ign_latency got %0d want 65", cyc); end
        checks++; if (d !== DIG_ABC) begin errors++; $display("FAIL ign_digest got %h want %h", d, DIG_ABC); end
        checks++; if (rb !== 0) begin errors++; $display("FAIL ign_ready_in_round got %0d cycles high want 0", rb); end
        extra = 0;
        repeat (80) begin @(posedge clk); #1; if (done === 1'b1) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ign_extra_done got %0d want 0", extra); end
    endtask

    task automatic test_abort;
        int cyc, rb, extra;
        logic [255:0] d;
        // digest_out holds DIG_ABC from the previous test
        accept_block(BLK_EMPTY, IV);
        repeat (30) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        checks++; if (digest_out !== DIG_ABC) begin errors++; $display("FAIL abort_digest got %h want %h", digest_out, DIG_ABC); end
        extra = 0;
        repeat (70) begin @(posedge clk); #1; if (done === 1'b1 || ready !== 1'b1) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL abort_idle got %0d bad cycles want 0", extra); end
        // abort in IDLE wins over start
        start = 1'b1; abort = 1'b1; block_in = BLK_EMPTY; state_in = IV;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_vs_start got ready %b want 1", ready); end
        accept_block(BLK_EMPTY, IV);
        wait_done(200, cyc, d, rb);
        checks++; if (cyc !== 65) begin errors++; $display("FAIL post_abort_latency got %0d want 65", cyc); end
        checks++; if (d !== DIG_EMPTY) begin errors++; $display("FAIL post_abort_digest got %h want %h", d, DIG_EMPTY); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int extra;
        accept_block(BLK_EMPTY, IV);
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", ready); end
        checks++; if (digest_out !== 256'h0) begin errors++; $display("FAIL rstmid_digest got %h want 0", digest_out); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        extra = 0;
        repeat (70) begin @(posedge clk); #1; if (done === 1'b1) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL rstmid_extra_done got %0d want 0", extra); end
        test_abc();
    endtask

    task automatic test_back_to_back;
        int c1, c2;
        logic [255:0] d1, d2;
        c1 = -1; c2 = -1; d1 = '0; d2 = '0;
        start = 1'b1; block_in = BLK_ABC; state_in = IV;
        @(posedge clk); #1;
        block_in = BLK_EMPTY;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (c1 < 0) begin c1 = i; d1 = digest_out; end
                else begin c2 = i; d2 = digest_out; start = 1'b0; break; end
            end
        end
        start = 1'b0;
        checks++; if (c1 !== 65) begin errors++; $display("FAIL b2b_first_latency got %0d want 65", c1); end
        checks++; if (d1 !== DIG_ABC) begin errors++; $display("FAIL b2b_first_digest got %h want %h", d1, DIG_ABC); end
        checks++; if (c2 - c1 !== 66) begin errors++; $display("FAIL b2b_spacing got %0d want 66", c2 - c1); end
        checks++; if (d2 !== DIG_EMPTY) begin errors++; $display("FAIL b2b_second_digest got %h want %h", d2, DIG_EMPTY); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_after got ready %b want 1", ready); end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_ignored_start();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
